if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I core; sits directly upstream of the decode stage.
- Reads instructions from the byte-wide unified memory port, one byte per access, and assembles each little-endian 32-bit word.
- Presents instruction and PC to decode through an internal IF/ID output register.
- Accepts taken-branch/jump redirects from decode and flushes the wrong-path instruction.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
stall_i  in  1  decode cannot accept; hold output register
jump_i  in  1  redirect request from decode (decode jump_o)
jump_addr_i  in  32  redirect target (decode jump_addr_o)
mem_rd_o  out  1  byte read request
mem_addr_o  out  32  byte address of request
mem_data_i  in  8  read byte, valid when mem_ack_i=1
mem_ack_i  in  1  current request completed this cycle
inst_o  out  32  instruction to decode; 0 when invalid
pc_o  out  32  instruction address + 4; decode relies on this offset for branch targets
inst_valid_o  out  1  inst_o/pc_o hold a live instruction

Behaviour:
- Reset (rst=0, async): pc<=RESET_PC, cnt<=0, state<=S_REQ, hold register empty, all outputs 0. mem_rd_o=0 while in reset.
- State S_REQ: mem_rd_o=1, mem_addr_o=pc+cnt (mod 2^32).
  - On mem_ack_i, mem_data_i is stored in byte lane cnt. Byte 0 is inst[7:0].
  - cnt increments on ack for cnt<3.
  - Ack with cnt=3 completes the word.
- Word completion, output register free (inst_valid_o=0, or stall_i=0 this cycle):
  - Next edge: inst_o<=word, pc_o<=pc+4, inst_valid_o<=1, pc<=pc+4, cnt<=0.
  - Remain in S_REQ; next request is issued the following cycle.
- Word completion, output register occupied (inst_valid_o=1 and stall_i=1): word goes to the hold register, pc<=pc+4, cnt<=0, state<=S_HOLD.
- S_HOLD: mem_rd_o=0. On the first cycle with stall_i=0, the hold word moves into the output register, the hold register empties, state<=S_REQ.
- Consumption: an edge with inst_valid_o=1 and stall_i=0 consumes the output. If no replacement arrives that edge, inst_valid_o<=0 and inst_o<=0 (NOP bubble).
- stall_i=1 freezes inst_o/pc_o/inst_valid_o. Fetching still proceeds.
- Redirect: jump_i=1 at an edge has priority over stall_i, completion and hold. Next state:
  - pc<=jump_addr_i, cnt<=0, state<=S_REQ, hold register emptied.
  - inst_valid_o<=0, inst_o<=0, pc_o<=0.
  - A byte acked in the same cycle is discarded. The first request to the new target is issued the cycle after.
- Misaligned targets (addr[1:0]!=0) are fetched as four consecutive bytes; no exception.
- Address wrap: 32'hFFFF_FFFC+4 -> 0. pc_o wraps identically.
- mem_ack_i while mem_rd_o=0 is ignored.
- Minimum latency: 4 cycles per instruction with single-cycle ack.

Optional Feature:
- FETCH_SKID_EN defined:
  - Entering S_HOLD does not stop fetching. FSM keeps requesting bytes 0..2 of the next instruction (pc already advanced).
  - The byte-3 request is withheld (mem_rd_o=0) while the hold register is full.
  - Drain order: hold word to output first, then the next completion.
  - jump_i flushes the hold register and partial bytes.
- Undefined: S_HOLD issues no requests, as described in Behaviour.

Test Plan:
- Reset release with RESET_PC=0; memory bytes 0..3 = 93 00 10 00, ack every cycle -> mem_addr_o 0,1,2,3; after 4th ack inst_o=32'h0010_0093, pc_o=4, inst_valid_o=1; next request addr 4.
- stall_i=1 held 10 cycles after first word -> inst_o stable; second word parked; mem_rd_o=0 (skid off). Release stall -> second word output with pc_o=8 on the next edge.
- jump_i=1, jump_addr_i=32'h100, asserted while cnt=2 -> next cycle inst_valid_o=0, inst_o=0, mem_addr_o=32'h100; byte acked in the jump cycle never appears in inst_o.
- jump_i and stall_i asserted together while hold register full -> hold word discarded; fetch restarts at target.
- pc=32'hFFFF_FFFC, word completes -> pc_o=0; next mem_addr_o=0.
- Async reset asserted mid-fetch with no clock edge -> mem_rd_o, inst_valid_o, inst_o drop to 0 immediately; after release fetch resumes at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: RV32I fetch stage assembling little-endian words from a byte-wide memory port
// Ports: clk; rst (async, active-low); stall_i/jump_i/jump_addr_i from decode;
//   mem_rd_o/mem_addr_o/mem_data_i/mem_ack_i byte memory port; inst_o/pc_o/inst_valid_o IF/ID register.
// Define FETCH_SKID_EN to keep fetching bytes 0..2 of the next word while a word is parked in the hold register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_ack_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o
);
  typedef enum logic {S_REQ, S_HOLD} state_t;
  state_t state, nxt_state;
  logic [31:0] pc, hold, hold_pc, word, pc4;
  logic [23:0] part;
  logic [1:0] cnt, nxt_cnt;
  logic ack, done, out_free, rd_nxt;
  assign mem_addr_o = pc + {30'd0, cnt};
  // acks arriving without an outstanding request are ignored
  assign ack = mem_ack_i & mem_rd_o;
  assign done = ack & (cnt == 2'd3);
  assign word = {mem_data_i, part};
  assign pc4 = pc + 32'd4;
  assign out_free = !inst_valid_o | !stall_i;
  always_comb begin
    nxt_cnt = jump_i | done ? 2'd0 : ack ? cnt + 2'd1 : cnt;
    nxt_state = jump_i ? S_REQ : done & !out_free ? S_HOLD : state == S_HOLD & !stall_i ? S_REQ : state;
`ifdef FETCH_SKID_EN
    // while parked, bytes 0..2 of the next word may still be fetched; byte 3 waits for the hold to drain
    rd_nxt = nxt_state == S_REQ | nxt_cnt != 2'd3;
`else
    rd_nxt = nxt_state == S_REQ;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_REQ;
      pc <= RESET_PC;
      cnt <= 2'd0;
      part <= '0;
      hold <= '0;
      hold_pc <= '0;
      inst_o <= '0;
      pc_o <= '0;
      inst_valid_o <= 1'b0;
      mem_rd_o <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      mem_rd_o <= rd_nxt;
      if (jump_i) begin
        pc <= jump_addr_i;
        inst_o <= '0;
        pc_o <= '0;
        inst_valid_o <= 1'b0;
      end else begin
        if (ack & !done) part[{cnt, 3'b000} +: 8] <= mem_data_i;
        if (done) pc <= pc4;
        if (done & !out_free) begin
          hold <= word;
          hold_pc <= pc4;
        end
        if (done & out_free) begin
          inst_o <= word;
          pc_o <= pc4;
          inst_valid_o <= 1'b1;
        end else if (state == S_HOLD & !stall_i) begin
          inst_o <= hold;
          pc_o <= hold_pc;
          inst_valid_o <= 1'b1;
        end else if (out_free) begin
          inst_o <= '0;
          inst_valid_o <= 1'b0;
        end
      end
    end
  end
endmodule
